sdram_rd_checker: RTL and testbench
===================================

SDRAM_RD_CHECKER -- requirements
Module: sdram_rd_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, read data width.
REQ-002 SHALL have parameter BURST_LEN, default 10, words drained per read burst.
REQ-003 SHALL have parameter TOTAL_WORDS, default 30, words checked per run (1..1023).
REQ-004 SHALL have parameter START_VAL, default 1, expected value of first word.
REQ-005 SHALL have parameter TIMEOUT, default 4096, max idle cycles waiting for FIFO data.
REQ-006 SHALL have port sys_clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port sys_rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have port start  in  1  single-cycle arm pulse.
REQ-009 SHALL have port rd_fifo_num  in  10  read-FIFO fill level.
REQ-010 SHALL have port rd_fifo_rd_data  in  DATA_W  read-FIFO data, valid one cycle after rd_fifo_rd_req.
REQ-011 SHALL have port rd_fifo_rd_req  out  1  read-FIFO read enable.
REQ-012 SHALL have port read_valid  out  1  SDRAM read enable to controller.
REQ-013 SHALL have port busy  out  1  run in progress.
REQ-014 SHALL have port done  out  1  run finished; held until next start.
REQ-015 SHALL have port pass  out  1  valid with done; 1 = zero errors, no timeout.
REQ-016 SHALL have port timeout  out  1  run aborted waiting for data.
REQ-017 SHALL have port err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
REQ-018 SHALL have port first_err_idx  out  10  word index (0-based) of first mismatch.
REQ-019 SHALL have port word_cnt  out  10  words compared this run.

Function
REQ-020 SHALL implement states IDLE, WAIT, READ, DRAIN, DONE.
REQ-021 IDLE: start -> WAIT; clear err_cnt, word_cnt, first_err_idx, timeout, done, pass; expected <= START_VAL; remaining <= TOTAL_WORDS.
REQ-022 read_valid SHALL be 1 from WAIT entry until requested-word count reaches TOTAL_WORDS, else 0.
REQ-023 WAIT: burst = min(BURST_LEN, remaining); when rd_fifo_num >= burst -> READ, load burst counter, clear timeout counter.
REQ-024 WAIT: timeout counter increments each cycle; reaching TIMEOUT-1 -> DONE with timeout=1.
REQ-025 READ: rd_fifo_rd_req SHALL be 1 for exactly burst consecutive cycles, then -> DRAIN; remaining decremented by burst.
REQ-026 DRAIN: one cycle, rd_fifo_rd_req=0; -> DONE if remaining==0, else -> WAIT.
REQ-027 Data-valid strobe SHALL be rd_fifo_rd_req delayed one cycle; compare rd_fifo_rd_data against expected on each strobe.
REQ-028 Each strobe: word_cnt +1, expected +1 modulo 2^DATA_W (wraps FFFF->0000).
REQ-029 Mismatch: err_cnt +1 saturating; if err_cnt was 0, first_err_idx <= current word_cnt.
REQ-030 DONE: done=1, busy=0, pass = (err_cnt==0 && !timeout); start -> WAIT with REQ-021 clears.
REQ-031 busy SHALL be 1 in WAIT, READ, DRAIN; 0 in IDLE, DONE.
REQ-032 start in WAIT, READ or DRAIN SHALL be ignored.
REQ-033 rd_fifo_rd_req SHALL never be 1 outside READ, hence never with rd_fifo_num below remaining burst (no FIFO underflow).

Reset
REQ-034 sys_rst SHALL asynchronously force IDLE, all outputs 0, all counters 0, expected = START_VAL.
REQ-035 sys_rst asserted mid-burst SHALL drop rd_fifo_rd_req and read_valid in the same cycle; any pending data strobe discarded.
REQ-036 After sys_rst release, block SHALL stay in IDLE until start.

Verification
REQ-037 Defaults; FIFO model fed 1..30; start -> 3 bursts of 10 req cycles, done=1, pass=1, err_cnt=0, word_cnt=30.
REQ-038 Word 13 corrupted to 16'h00AA -> err_cnt=1, first_err_idx=12, pass=0, word_cnt=30.
REQ-039 TOTAL_WORDS=25 -> bursts 10,10,5; rd_fifo_rd_req high exactly 25 cycles total; pass=1.
REQ-040 rd_fifo_num held at 9 after start, TIMEOUT=64 -> no req, timeout=1, done=1, pass=0 after 64 WAIT cycles.
REQ-041 START_VAL=16'hFFFE, TOTAL_WORDS=4, data FFFE,FFFF,0000,0001 -> pass=1 (wrap).
REQ-042 sys_rst pulsed during second READ burst -> req and read_valid 0 immediately, all outputs 0; fresh start completes with pass=1.

Source files
------------

// File: rtl/sdram_rd_checker.sv
// rtl/sdram_rd_checker.sv - SDRAM read-back checker: drains the read FIFO in bursts and compares against an incrementing pattern
module sdram_rd_checker #(
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 10,
  parameter int TOTAL_WORDS = 30,
  parameter int START_VAL   = 1,
  parameter int TIMEOUT     = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [9:0]        rd_fifo_num,
  input  logic [DATA_W-1:0] rd_fifo_rd_data,
  output logic              rd_fifo_rd_req,
  output logic              read_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [9:0]        first_err_idx,
  output logic [9:0]        word_cnt
);

  localparam logic [DATA_W-1:0] START_W = DATA_W'(START_VAL);
  localparam logic [9:0]        TOTAL_W = 10'(TOTAL_WORDS);
  localparam logic [9:0]        BURST_W = 10'(BURST_LEN);
  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [9:0]        remaining;
  logic [9:0]        bcnt;
  logic [9:0]        req_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] expected;
  logic              rd_vld;
  logic [9:0]        burst;
  logic              fifo_ready;
  logic              launch;

  // last burst of a run may be shorter than BURST_LEN
  assign burst      = (remaining < BURST_W) ? remaining : BURST_W;
  assign fifo_ready = (rd_fifo_num >= burst);
  assign launch     = start && (state == S_IDLE || state == S_DONE);

  assign rd_fifo_rd_req = (state == S_READ);
  assign busy           = (state == S_WAIT) || (state == S_READ) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign pass           = done && (err_cnt == 16'd0) && !timeout;
  assign read_valid     = busy && (req_cnt != TOTAL_W);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
      S_WAIT: begin
        if (fifo_ready)             state_nxt = S_READ;
        else if (to_cnt == TO_LAST) state_nxt = S_DONE;
      end
      S_READ:  if (bcnt == 10'd1) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = (remaining == 10'd0) ? S_DONE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      remaining     <= '0;
      bcnt          <= '0;
      req_cnt       <= '0;
      to_cnt        <= '0;
      expected      <= START_W;
      rd_vld        <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      word_cnt      <= '0;
    end else begin
      rd_vld <= rd_fifo_rd_req;
      if (launch) begin
        remaining     <= TOTAL_W;
        req_cnt       <= '0;
        to_cnt        <= '0;
        expected      <= START_W;
        timeout       <= 1'b0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        word_cnt      <= '0;
      end else begin
        case (state)
          S_WAIT: begin
            if (fifo_ready) begin
              bcnt   <= burst;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              if (to_cnt == TO_LAST) timeout <= 1'b1;
            end
          end
          S_READ: begin
            bcnt      <= bcnt - 10'd1;
            remaining <= remaining - 10'd1;
            req_cnt   <= req_cnt + 10'd1;
          end
          default: ;
        endcase
        // data returned for the previous cycle's request
        if (rd_vld) begin
          word_cnt <= word_cnt + 10'd1;
          expected <= expected + 1'b1;
          if (rd_fifo_rd_data != expected) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0)    first_err_idx <= word_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_rd_checker.sv
// tb/tb_sdram_rd_checker.sv - directed bench for sdram_rd_checker with four parameter sets and read-FIFO models
`timescale 1ns/1ps
module tb_sdram_rd_checker;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start   [4];
  logic [9:0]  num     [4];
  logic [15:0] rdata   [4];
  logic        req     [4];
  logic        rv      [4];
  logic        busy    [4];
  logic        done    [4];
  logic        pass    [4];
  logic        tmo     [4];
  logic [15:0] err     [4];
  logic [9:0]  fidx    [4];
  logic [9:0]  wcnt    [4];

  logic [15:0] mem       [4][32];
  int          depth     [4];
  logic        force_en  [4];
  logic [9:0]  force_val [4];
  logic        clr       [4];
  int          ptr       [4];
  int          bidx      [4];
  int          run       [4];
  int          req_tot   [4];
  int          blen      [4][4];
  logic        req_d     [4];
  logic        undr      [4];

  int total;
  int bad;
  int cyc;

  always #5 sys_clk = ~sys_clk;

  sdram_rd_checker u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start[0]), .rd_fifo_num(num[0]),
    .rd_fifo_rd_data(rdata[0]), .rd_fifo_rd_req(req[0]), .read_valid(rv[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .timeout(tmo[0]), .err_cnt(err[0]),
    .first_err_idx(fidx[0]), .word_cnt(wcnt[0]));

  sdram_rd_checker #(.TOTAL_WORDS(25)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start[1]), .rd_fifo_num(num[1]),
    .rd_fifo_rd_data(rdata[1]), .rd_fifo_rd_req(req[1]), .read_valid(rv[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .timeout(tmo[1]), .err_cnt(err[1]),
    .first_err_idx(fidx[1]), .word_cnt(wcnt[1]));

  sdram_rd_checker #(.TIMEOUT(64)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start[2]), .rd_fifo_num(num[2]),
    .rd_fifo_rd_data(rdata[2]), .rd_fifo_rd_req(req[2]), .read_valid(rv[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .timeout(tmo[2]), .err_cnt(err[2]),
    .first_err_idx(fidx[2]), .word_cnt(wcnt[2]));

  sdram_rd_checker #(.START_VAL(16'hFFFE), .TOTAL_WORDS(4)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start[3]), .rd_fifo_num(num[3]),
    .rd_fifo_rd_data(rdata[3]), .rd_fifo_rd_req(req[3]), .read_valid(rv[3]), .busy(busy[3]),
    .done(done[3]), .pass(pass[3]), .timeout(tmo[3]), .err_cnt(err[3]),
    .first_err_idx(fidx[3]), .word_cnt(wcnt[3]));

  // pre-filled read FIFO per instance; records burst lengths and underflow
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign num[g] = force_en[g] ? force_val[g] : 10'(depth[g] - ptr[g]);
    always @(posedge sys_clk) begin
      if (clr[g]) begin
        ptr[g]     <= 0;
        bidx[g]    <= 0;
        run[g]     <= 0;
        req_tot[g] <= 0;
        req_d[g]   <= 1'b0;
        undr[g]    <= 1'b0;
        rdata[g]   <= '0;
      end else begin
        req_d[g] <= req[g];
        if (req[g]) begin
          rdata[g]   <= mem[g][ptr[g] % 32];
          ptr[g]     <= ptr[g] + 1;
          req_tot[g] <= req_tot[g] + 1;
          run[g]     <= run[g] + 1;
          if (ptr[g] >= depth[g]) undr[g] <= 1'b1;
        end else if (req_d[g]) begin
          if (bidx[g] < 4) blen[g][bidx[g]] <= run[g];
          bidx[g] <= bidx[g] + 1;
          run[g]  <= 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int g, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) mem[g][i] = 16'(base + 16'(i));
    depth[g] = n;
    clr[g] = 1'b1;
    @(negedge sys_clk);
    clr[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge sys_clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int maxc);
    int c;
    c = 0;
    while (!done[g] && c < maxc) begin
      @(negedge sys_clk);
      c++;
    end
    if (!done[g]) chk("wait_done", 32'd0, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sys_rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start[g] = 1'b0; clr[g] = 1'b1; force_en[g] = 1'b0; force_val[g] = '0; depth[g] = 0;
      for (int i = 0; i < 32; i++) mem[g][i] = '0;
    end
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_tmo",  tmo[0], 0);
    chk("rst_req",  req[0], 0);
    chk("rst_rv",   rv[0], 0);
    chk("rst_err",  err[0], 0);
    chk("rst_wcnt", wcnt[0], 0);
    chk("rst_fidx", fidx[0], 0);
    sys_rst = 1'b0;
    for (int g = 0; g < 4; g++) clr[g] = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("idle_busy", busy[0], 0);
    chk("idle_done", done[0], 0);

    // nominal run: 30 words in three bursts of 10
    load(0, 30, 16'd1);
    pulse_start(0);
    chk("t1_busy", busy[0], 1);
    chk("t1_rv",   rv[0], 1);
    wait_done(0, 500);
    chk("t1_done", done[0], 1);
    chk("t1_pass", pass[0], 1);
    chk("t1_err",  err[0], 0);
    chk("t1_wcnt", wcnt[0], 30);
    chk("t1_nbur", bidx[0], 3);
    chk("t1_b0",   blen[0][0], 10);
    chk("t1_b1",   blen[0][1], 10);
    chk("t1_b2",   blen[0][2], 10);
    chk("t1_rv_end", rv[0], 0);
    chk("t1_undr", undr[0], 0);

    // word 13 corrupted, restart from DONE
    load(0, 30, 16'd1);
    mem[0][12] = 16'h00AA;
    pulse_start(0);
    chk("t2_clr_done", done[0], 0);
    wait_done(0, 500);
    chk("t2_err",  err[0], 1);
    chk("t2_fidx", fidx[0], 12);
    chk("t2_pass", pass[0], 0);
    chk("t2_wcnt", wcnt[0], 30);

    // 25 words: bursts 10,10,5
    load(1, 25, 16'd1);
    pulse_start(1);
    wait_done(1, 500);
    chk("t3_pass", pass[1], 1);
    chk("t3_reqs", req_tot[1], 25);
    chk("t3_b0",   blen[1][0], 10);
    chk("t3_b1",   blen[1][1], 10);
    chk("t3_b2",   blen[1][2], 5);
    chk("t3_nbur", bidx[1], 3);
    chk("t3_undr", undr[1], 0);

    // FIFO stuck at 9 with TIMEOUT 64
    load(2, 30, 16'd1);
    force_en[2] = 1'b1;
    force_val[2] = 10'd9;
    pulse_start(2);
    cyc = 0;
    while (busy[2] && cyc < 200) begin
      cyc++;
      @(negedge sys_clk);
    end
    chk("t4_waitc", cyc, 64);
    chk("t4_done", done[2], 1);
    chk("t4_tmo",  tmo[2], 1);
    chk("t4_pass", pass[2], 0);
    chk("t4_reqs", req_tot[2], 0);
    chk("t4_wcnt", wcnt[2], 0);

    // expected value wraps FFFF -> 0000
    load(3, 4, 16'hFFFE);
    pulse_start(3);
    wait_done(3, 200);
    chk("t5_pass", pass[3], 1);
    chk("t5_wcnt", wcnt[3], 4);
    chk("t5_err",  err[3], 0);

    // reset in the middle of the second burst
    load(0, 30, 16'd1);
    pulse_start(0);
    cyc = 0;
    while (!(bidx[0] == 1 && req[0]) && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("t6_in_burst", req[0], 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("t6_req",  req[0], 0);
    chk("t6_rv",   rv[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_done", done[0], 0);
    chk("t6_wcnt", wcnt[0], 0);
    chk("t6_err",  err[0], 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("t6_idle", busy[0], 0);
    load(0, 30, 16'd1);
    pulse_start(0);
    wait_done(0, 500);
    chk("t6_pass", pass[0], 1);
    chk("t6_wcnt2", wcnt[0], 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
